// File: rtl/decode_queue.sv
// Decoded-instruction queue: decodes MIPS-style words at enqueue and presents the head entry.
// Optional macro DECODE_QUEUE_STATS_EN adds a saturating popped-branch counter.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_iw,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_iw,
  output logic          out_rtype,
  output logic          out_itype,
  output logic          out_jtype,
  output logic          out_is_arith,
  output logic          out_is_branch,
  output logic          out_link,
  output logic          out_sign_reqd,
  output logic [4:0]    out_cond,
  output logic          out_delay_slot,
  output logic [CW-1:0] count
`ifdef DECODE_QUEUE_STATS_EN
  ,
  output logic [15:0]   branch_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] iw;
    logic        rtype;
    logic        itype;
    logic        jtype;
    logic        is_arith;
    logic        is_branch;
    logic        link;
    logic        sign_reqd;
    logic [4:0]  cond;
    logic        delay_slot;
  } entry_t;

  // cond bit order is {P,N,Z,EQ,NEQ}
  function automatic entry_t decode(input logic [31:0] iw, input logic ds);
    entry_t     e;
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    op = iw[31:26];
    rt = iw[20:16];
    fn = iw[5:0];
    e = '0;
    e.iw         = iw;
    e.delay_slot = ds;
    e.rtype      = (op == 6'h00);
    e.jtype      = (op == 6'h02) || (op == 6'h03);
    e.itype      = !(e.rtype || e.jtype);
    case (op)
      6'h09: begin e.is_arith = 1'b1; e.sign_reqd = 1'b1; end
      6'h0C, 6'h0D, 6'h0E: e.is_arith = 1'b1;
      6'h0A, 6'h0B: e.sign_reqd = 1'b1;
      6'h04: begin e.is_branch = 1'b1; e.cond = 5'b00010; end
      6'h05: begin e.is_branch = 1'b1; e.cond = 5'b00001; end
      6'h06: begin e.is_branch = 1'b1; e.cond = 5'b01100; end
      6'h07: begin e.is_branch = 1'b1; e.cond = 5'b10000; end
      6'h03: e.link = 1'b1;
      6'h00: e.link = (fn == 6'h09);
      6'h01: begin
        case (rt)
          5'h00, 5'h10: begin e.is_branch = 1'b1; e.cond = 5'b01000; end
          5'h01, 5'h11: begin e.is_branch = 1'b1; e.cond = 5'b10100; end
          default: ;
        endcase
        e.link = (rt == 5'h10) || (rt == 5'h11);
      end
      default: ;
    endcase
    return e;
  endfunction

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           prev_ct;
  logic           push, pop, new_ct;
  entry_t         new_entry, head;

  always_comb begin
    in_ready  = (count != FULL);
    out_valid = (count != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    new_entry = decode(in_iw, prev_ct);
    new_ct    = new_entry.is_branch || new_entry.jtype ||
                (new_entry.rtype && ((in_iw[5:0] == 6'h08) || (in_iw[5:0] == 6'h09)));
    head      = out_valid ? mem[rptr] : '0;
  end

  assign out_iw         = head.iw;
  assign out_rtype      = head.rtype;
  assign out_itype      = head.itype;
  assign out_jtype      = head.jtype;
  assign out_is_arith   = head.is_arith;
  assign out_is_branch  = head.is_branch;
  assign out_link       = head.link;
  assign out_sign_reqd  = head.sign_reqd;
  assign out_cond       = head.cond;
  assign out_delay_slot = head.delay_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      prev_ct <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      prev_ct <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= new_entry;
        wptr      <= wptr + AW'(1);
        prev_ct   <= new_ct;
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef DECODE_QUEUE_STATS_EN
  // Deliberately survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      branch_count <= '0;
    else if (pop && head.is_branch && (branch_count != '1))
      branch_count <= branch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4).
module tb_decode_queue;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_iw, out_iw;
  logic        out_rtype, out_itype, out_jtype, out_is_arith, out_is_branch;
  logic        out_link, out_sign_reqd, out_delay_slot;
  logic [4:0]  out_cond;
  logic [2:0]  count;
`ifdef DECODE_QUEUE_STATS_EN
  logic [15:0] branch_count;
`endif
  logic [12:0] flags;

  int checks = 0;
  int failures = 0;

  decode_queue #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_iw(in_iw),
    .out_valid(out_valid), .out_ready(out_ready), .out_iw(out_iw),
    .out_rtype(out_rtype), .out_itype(out_itype), .out_jtype(out_jtype),
    .out_is_arith(out_is_arith), .out_is_branch(out_is_branch), .out_link(out_link),
    .out_sign_reqd(out_sign_reqd), .out_cond(out_cond), .out_delay_slot(out_delay_slot),
    .count(count)
`ifdef DECODE_QUEUE_STATS_EN
    , .branch_count(branch_count)
`endif
  );

  always #5 clk = ~clk;

  // {rtype,itype,jtype,is_arith,is_branch,link,sign_reqd,cond[4:0],delay_slot}
  assign flags = {out_rtype, out_itype, out_jtype, out_is_arith, out_is_branch,
                  out_link, out_sign_reqd, out_cond, out_delay_slot};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] iw);
    in_valid = 1'b1;
    in_iw    = iw;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_iw = '0;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_iw", out_iw, 32'd0);
    #10 rst_n = 1'b1;
    cyc();

    // LW into empty queue
    push(32'h8C020004);
    check("lw_valid", 32'(out_valid), 32'd1);
    check("lw_count", 32'(count), 32'd1);
    check("lw_iw", out_iw, 32'h8C020004);
    check("lw_flags", 32'(flags), 32'(13'b0100000_00000_0));
    pop();
    check("lw_pop_count", 32'(count), 32'd0);

    // BEQ then SLL: second entry sits in the delay slot
    push(32'h10220003);
    push(32'h00000000);
    check("beq_count", 32'(count), 32'd2);
    check("beq_flags", 32'(flags), 32'(13'b0100100_00010_0));
    pop();
    check("sll_flags", 32'(flags), 32'(13'b1000000_00000_1));
    pop();
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_iw", out_iw, 32'd0);
    check("empty_flags", 32'(flags), 32'd0);

    // BGEZAL, then REGIMM with unsupported rt
    push(32'h04110002);
    push(32'h04020002);
    check("bgezal_flags", 32'(flags), 32'(13'b0100110_10100_0));
    pop();
    check("regimm_rt2_flags", 32'(flags), 32'(13'b0100000_00000_1));
    check("regimm_rt2_iw", out_iw, 32'h04020002);
    pop();

    // Fill to DEPTH with ADDIU entries, consumer stalled
    for (int i = 0; i < 4; i++) push(32'h24000010 + 32'(i));
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head_flags", 32'(flags), 32'(13'b0101001_00000_0));
    push(32'hDEADBEEF);
    check("full_push_ignored", 32'(count), 32'd4);
    check("full_head_stable", out_iw, 32'h24000010);
    pop();
    check("pop1_count", 32'(count), 32'd3);
    check("pop1_head", out_iw, 32'h24000011);
    // Simultaneous push and pop across the pointer wrap
    out_ready = 1'b1; in_valid = 1'b1;
    in_iw = 32'h24000020; cyc();
    check("pp0_count", 32'(count), 32'd3);
    check("pp0_head", out_iw, 32'h24000012);
    in_iw = 32'h24000021; cyc();
    check("pp1_count", 32'(count), 32'd3);
    check("pp1_head", out_iw, 32'h24000013);
    in_iw = 32'h24000022; cyc();
    check("pp2_count", 32'(count), 32'd3);
    check("pp2_head", out_iw, 32'h24000020);
    in_valid = 1'b0;
    cyc();
    check("drain0_head", out_iw, 32'h24000021);
    cyc();
    check("drain1_head", out_iw, 32'h24000022);
    cyc();
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);

    // Flush at count=3 with push and pop requested in the same cycle
    push(32'h8C020004);
    push(32'h8C020004);
    push(32'h0C000000);
    check("preflush_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_iw = 32'h10220003;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    push(32'h8C020004);
    check("postflush_flags", 32'(flags), 32'(13'b0100000_00000_0));
    pop();

    // Async reset mid-operation with two entries queued
    push(32'h10220003);
    push(32'h0C000000);
    pop();
`ifdef DECODE_QUEUE_STATS_EN
    check("stats_branches", 32'(branch_count), 32'd3);
`endif
    check("jal_flags", 32'(flags), 32'(13'b0010010_00000_1));
    push(32'h8C020004);
    check("prereset_count", 32'(count), 32'd2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("areset_count", 32'(count), 32'd0);
    check("areset_valid", 32'(out_valid), 32'd0);
    check("areset_iw", out_iw, 32'd0);
    check("areset_flags", 32'(flags), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
`ifdef DECODE_QUEUE_STATS_EN
    check("areset_stats", 32'(branch_count), 32'd0);
`endif
    #2 rst_n = 1'b1;
    cyc();
    push(32'h8C020004);
    check("postreset_count", 32'(count), 32'd1);
    check("postreset_flags", 32'(flags), 32'(13'b0100000_00000_0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
